// File: rtl/instruction_loader.sv
// Instruction-bank loader: turns a framed byte stream into big-endian words on the bank write port.
// Optional INSTRUCTION_LOADER_CSUM_EN: the frame's last byte is an XOR checksum of the payload.
module instruction_loader #(
  parameter int unsigned INST_WIDTH = 64,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [7:0]  LOAD_CMD   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [INST_WIDTH-1:0] wr_data,
  output logic                  fetch_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned BYTES = INST_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LOAD, S_DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [INST_WIDTH-1:0] r_word, w_word_nxt;
  logic [7:0]            r_addr_hi, w_addr_hi_nxt;
  logic [CNT_W-1:0]      r_addr, w_addr_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [INST_WIDTH-1:0] r_wr_data, w_wr_data_nxt;
  logic                  r_fetch_hold, w_fetch_hold_nxt;
  logic                  r_load_done, w_load_done_nxt;
  logic                  r_load_error, w_load_error_nxt;
  logic [CNT_W-1:0]      r_words, w_words_nxt;
`ifdef INSTRUCTION_LOADER_CSUM_EN
  logic [7:0]            r_csum, w_csum_nxt;
`endif

  logic [INST_WIDTH-1:0] w_word_shift;
  logic [15:0]           w_addr16;
  logic                  w_addr_ovf;

  assign w_word_shift = (r_word << 8) | INST_WIDTH'(in_data);
  assign w_addr16     = {r_addr_hi, in_data};
  // Counter is one bit wider than the bank address so running off the end is visible.
  assign w_addr_ovf   = (r_addr >= CNT_W'(DEPTH));

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_word_nxt       = r_word;
    w_addr_hi_nxt    = r_addr_hi;
    w_addr_nxt       = r_addr;
    w_wr_en_nxt      = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_load_done_nxt  = 1'b0;
    w_load_error_nxt = r_load_error;
    w_words_nxt      = r_words;
    // Hold stays up through the cycle that carries the final write or the error.
    w_fetch_hold_nxt = (r_state == S_ADDR_HI) || (r_state == S_ADDR_LO) || (r_state == S_LOAD);
`ifdef INSTRUCTION_LOADER_CSUM_EN
    w_csum_nxt       = r_csum;
`endif

    if (in_valid) begin
      case (r_state)
        S_IDLE: begin
          if (!in_last) begin
            if (in_data == LOAD_CMD) begin
              w_state_nxt      = S_ADDR_HI;
              w_load_error_nxt = 1'b0;
              w_words_nxt      = '0;
              w_fetch_hold_nxt = 1'b1;
              w_idx_nxt        = '0;
`ifdef INSTRUCTION_LOADER_CSUM_EN
              w_csum_nxt       = '0;
`endif
            end else begin
              w_state_nxt = S_DRAIN;
            end
          end
        end
        S_ADDR_HI: begin
          if (in_last) begin
            w_load_error_nxt = 1'b1;
            w_state_nxt      = S_IDLE;
          end else begin
            w_addr_hi_nxt = in_data;
            w_state_nxt   = S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (in_last) begin
            w_load_error_nxt = 1'b1;
            w_state_nxt      = S_IDLE;
          end else begin
            w_addr_nxt  = CNT_W'(ADDR_WIDTH'(w_addr16));
            w_idx_nxt   = '0;
            w_state_nxt = S_LOAD;
          end
        end
        S_LOAD: begin
`ifdef INSTRUCTION_LOADER_CSUM_EN
          if (in_last) begin
            // Checksum byte: must land on a word boundary after at least one word.
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            if ((r_idx != '0) || (r_words == '0) || (in_data != r_csum)) begin
              w_load_error_nxt = 1'b1;
            end else begin
              w_load_done_nxt = 1'b1;
            end
          end else begin
            w_csum_nxt = r_csum ^ in_data;
`endif
            w_word_nxt = w_word_shift;
            if (r_idx == LAST_IDX) begin
              w_idx_nxt = '0;
              if (w_addr_ovf) begin
                w_load_error_nxt = 1'b1;
                w_state_nxt      = S_DRAIN;
              end else begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = ADDR_WIDTH'(r_addr);
                w_wr_data_nxt = w_word_shift;
                w_addr_nxt    = r_addr + CNT_W'(1);
                w_words_nxt   = r_words + CNT_W'(1);
              end
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
`ifdef INSTRUCTION_LOADER_CSUM_EN
          end
`else
          if (in_last) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            if (r_idx != LAST_IDX) begin
              w_load_error_nxt = 1'b1;
            end else if (!w_addr_ovf) begin
              w_load_done_nxt = 1'b1;
            end
          end
`endif
        end
        S_DRAIN: begin
          if (in_last) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_word       <= '0;
      r_addr_hi    <= '0;
      r_addr       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_fetch_hold <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_words      <= '0;
`ifdef INSTRUCTION_LOADER_CSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_word       <= w_word_nxt;
      r_addr_hi    <= w_addr_hi_nxt;
      r_addr       <= w_addr_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_fetch_hold <= w_fetch_hold_nxt;
      r_load_done  <= w_load_done_nxt;
      r_load_error <= w_load_error_nxt;
      r_words      <= w_words_nxt;
`ifdef INSTRUCTION_LOADER_CSUM_EN
      r_csum       <= w_csum_nxt;
`endif
    end
  end

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign fetch_hold   = r_fetch_hold;
  assign load_done    = r_load_done;
  assign load_error   = r_load_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader (INST_WIDTH=32, DEPTH=16).
module tb_instruction_loader;

  localparam int unsigned IW = 32;
  localparam int unsigned DP = 16;
  localparam int unsigned AW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
    logic          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_last = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic          fetch_hold;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  bit   hold_seen = 1'b0;
  exp_t exp_q[$];

  instruction_loader #(.INST_WIDTH(IW), .DEPTH(DP), .ADDR_WIDTH(AW), .LOAD_CMD(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .fetch_hold(fetch_hold),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor: every bank write must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (fetch_hold) hold_seen = 1'b1;
    if (load_done) done_cnt++;
    if (wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%h expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data, load_done} !== {e.addr, e.data, e.done}) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h done=%0b expected addr=%0d data=%h done=%0b",
                   wr_addr, wr_data, load_done, e.addr, e.data, e.done);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b[$], input bit mark_last, input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      @(posedge clk); #1;
      if (gaps) begin
        int n;
        in_valid = 1'b0;
        n = $urandom_range(0, 2);
        repeat (n) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = b[i];
      in_last  = mark_last && (i == b.size() - 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wr_en, load_done, load_error, fetch_hold} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got %b expected 0000", {wr_en, load_done, load_error, fetch_hold});
    end
    checks++;
    if ({wr_addr, wr_data, words_loaded} !== '0) begin
      failures++;
      $display("FAIL reset_bus got addr=%0d data=%h words=%0d expected 0", wr_addr, wr_data, words_loaded);
    end
    rst = 1'b1;
  endtask

  task automatic test_two_words();
    logic [7:0] f[$];
    int d0;
    f = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_q.push_back('{addr: 4'd2, data: 32'h11223344, done: 1'b0});
    exp_q.push_back('{addr: 4'd3, data: 32'h55667788, done: 1'b1});
    d0 = done_cnt;
    hold_seen = 1'b0;
    send_frame(f, 1'b1, 1'b0);
    settle();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL two_words_pending got %0d expected 0", exp_q.size()); end
    checks++;
    if (words_loaded !== 5'd2) begin failures++; $display("FAIL two_words_count got %0d expected 2", words_loaded); end
    checks++;
    if (load_error !== 1'b0) begin failures++; $display("FAIL two_words_error got %b expected 0", load_error); end
    checks++;
    if (fetch_hold !== 1'b0) begin failures++; $display("FAIL two_words_hold_after got %b expected 0", fetch_hold); end
    checks++;
    if (hold_seen !== 1'b1) begin failures++; $display("FAIL two_words_hold_seen got %b expected 1", hold_seen); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL two_words_done got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_overflow();
    logic [7:0] f[$];
    int d0;
    f = '{8'hA5, 8'h00, 8'h0F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    exp_q.push_back('{addr: 4'd15, data: 32'h01020304, done: 1'b0});
    d0 = done_cnt;
    send_frame(f, 1'b1, 1'b0);
    settle();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_pending got %0d expected 0", exp_q.size()); end
    checks++;
    if (load_error !== 1'b1) begin failures++; $display("FAIL ovf_error got %b expected 1", load_error); end
    checks++;
    if (words_loaded !== 5'd1) begin failures++; $display("FAIL ovf_count got %0d expected 1", words_loaded); end
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL ovf_done got %0d expected 0", done_cnt - d0); end
  endtask

  task automatic test_short_frame();
    logic [7:0] f[$];
    int d0;
    f = '{8'hA5, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE};
    d0 = done_cnt;
    send_frame(f, 1'b1, 1'b0);
    settle();
    checks++;
    if (load_error !== 1'b1) begin failures++; $display("FAIL short_error got %b expected 1", load_error); end
    checks++;
    if (words_loaded !== 5'd0) begin failures++; $display("FAIL short_count got %0d expected 0", words_loaded); end
    f = '{8'hA5, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
    exp_q.push_back('{addr: 4'd4, data: 32'h10203040, done: 1'b1});
    send_frame(f, 1'b1, 1'b0);
    settle();
    checks++;
    if (load_error !== 1'b0) begin failures++; $display("FAIL short_recover_error got %b expected 0", load_error); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL short_recover_pending got %0d expected 0", exp_q.size()); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL short_done got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_addr_error();
    logic [7:0] f[$];
    f = '{8'hA5, 8'h00};
    send_frame(f, 1'b1, 1'b0);
    settle();
    checks++;
    if ({load_error, fetch_hold} !== 2'b10) begin
      failures++;
      $display("FAIL addr_last got err=%b hold=%b expected err=1 hold=0", load_error, fetch_hold);
    end
  endtask

  task automatic test_non_cmd_then_gaps();
    logic [7:0] f[$];
    f = '{8'h3C, 8'h01, 8'h02};
    hold_seen = 1'b0;
    send_frame(f, 1'b1, 1'b0);
    settle();
    checks++;
    if (hold_seen !== 1'b0) begin failures++; $display("FAIL noncmd_hold got %b expected 0", hold_seen); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL noncmd_pending got %0d expected 0", exp_q.size()); end
    f = '{8'hA5, 8'h00, 8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11};
    exp_q.push_back('{addr: 4'd5, data: 32'hAABBCCDD, done: 1'b0});
    exp_q.push_back('{addr: 4'd6, data: 32'hEEFF0011, done: 1'b1});
    send_frame(f, 1'b1, 1'b1);
    settle();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL gaps_pending got %0d expected 0", exp_q.size()); end
    checks++;
    if ({load_error, words_loaded} !== {1'b0, 5'd2}) begin
      failures++;
      $display("FAIL gaps_status got err=%b words=%0d expected err=0 words=2", load_error, words_loaded);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f[$];
    f = '{8'hA5, 8'h00, 8'h00, 8'hDE, 8'hAD};
    send_frame(f, 1'b0, 1'b0);
    checks++;
    if (fetch_hold !== 1'b1) begin failures++; $display("FAIL midreset_hold_before got %b expected 1", fetch_hold); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({wr_en, load_done, load_error, fetch_hold, words_loaded} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got %b expected 0", {wr_en, load_done, load_error, fetch_hold, words_loaded});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    f = '{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    exp_q.push_back('{addr: 4'd1, data: 32'hCAFEBABE, done: 1'b1});
    send_frame(f, 1'b1, 1'b0);
    settle();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL midreset_pending got %0d expected 0", exp_q.size()); end
  endtask

`ifdef INSTRUCTION_LOADER_CSUM_EN
  task automatic test_checksum();
    logic [7:0] f[$];
    int d0;
    f = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    exp_q.push_back('{addr: 4'd0, data: 32'h01020304, done: 1'b0});
    d0 = done_cnt;
    send_frame(f, 1'b1, 1'b0);
    settle();
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL csum_ok_done got %0d expected 1", done_cnt - d0); end
    checks++;
    if (load_error !== 1'b0) begin failures++; $display("FAIL csum_ok_error got %b expected 0", load_error); end
    f = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    exp_q.push_back('{addr: 4'd0, data: 32'h01020304, done: 1'b0});
    d0 = done_cnt;
    send_frame(f, 1'b1, 1'b0);
    settle();
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL csum_bad_done got %0d expected 0", done_cnt - d0); end
    checks++;
    if (load_error !== 1'b1) begin failures++; $display("FAIL csum_bad_error got %b expected 1", load_error); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL csum_pending got %0d expected 0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef INSTRUCTION_LOADER_CSUM_EN
    test_checksum();
`else
    test_two_words();
    test_overflow();
    test_short_frame();
    test_addr_error();
    test_non_cmd_then_gaps();
    test_reset_mid_frame();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
